// File: rtl/id_ex_stage_ctl_pkg.sv
// Shared pipeline definitions: default datapath widths and the ID/EX control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_stage_ctl_pkg;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int ALUOP_W = 4;
  localparam int MEMWE_W = 4;
  localparam int MEMRW_W = 2;

  // Control decoded in ID and consumed in EX/MEM/WB.
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dst;
    logic [MEMWE_W-1:0] mem_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic [MEMRW_W-1:0] mem_read_width;
    logic               reg_write;
  } idex_ctl_t;

  localparam idex_ctl_t IDEX_CTL_NOP = '0;

  // An invalid slot must not have side effects: clear every flag that
  // writes state or steers the datapath, but keep the opcode-like fields.
  function automatic idex_ctl_t ctl_squash_flags(input idex_ctl_t c);
    idex_ctl_t r;
    r            = c;
    r.alu_src    = 1'b0;
    r.reg_dst    = 1'b0;
    r.mem_write  = '0;
    r.mem_to_reg = 1'b0;
    r.mem_read   = 1'b0;
    r.reg_write  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_ctl_if.sv
// ID/EX stage bus: ID-side fields and controls in, registered EX-side fields out.
// Latency: n/a (wiring only).
// Backpressure: hold freezes the stage; load_use_stall asks upstream to hold.
interface id_ex_stage_ctl_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 4,
  parameter int MEMWE_W = 4,
  parameter int MEMRW_W = 2,
  parameter int CNT_W   = 16
);
  import id_ex_stage_ctl_pkg::*;

  // stage controls
  logic               flush;
  logic               hold;
  logic               cnt_clear;
  // ID side
  logic               in_valid;
  logic [RADDR_W-1:0] rs, rt, rd;
  logic [ALUOP_W-1:0] alu_op;
  logic [DATA_W-1:0]  sig_ext, read_data1, read_data2;
  logic               alu_src, reg_dst, mem_to_reg, mem_read, reg_write;
  logic [MEMWE_W-1:0] mem_write;
  logic [MEMRW_W-1:0] mem_read_width;
  // EX side
  logic               valid_out;
  logic [RADDR_W-1:0] rs_out, rt_out, rd_out, dest_out;
  logic [ALUOP_W-1:0] alu_op_out;
  logic [DATA_W-1:0]  sig_ext_out, read_data1_out, read_data2_out;
  logic               alu_src_out, reg_dst_out, mem_to_reg_out, mem_read_out, reg_write_out;
  logic [MEMWE_W-1:0] mem_write_out;
  logic [MEMRW_W-1:0] mem_read_width_out;
  logic               load_use_stall;
  logic [CNT_W-1:0]   bubble_count;

  modport master (
    output flush, hold, cnt_clear, in_valid, rs, rt, rd, alu_op, sig_ext,
           read_data1, read_data2, alu_src, reg_dst, mem_to_reg, mem_read,
           reg_write, mem_write, mem_read_width,
    input  valid_out, rs_out, rt_out, rd_out, dest_out, alu_op_out, sig_ext_out,
           read_data1_out, read_data2_out, alu_src_out, reg_dst_out,
           mem_to_reg_out, mem_read_out, reg_write_out, mem_write_out,
           mem_read_width_out, load_use_stall, bubble_count
  );

  modport slave (
    input  flush, hold, cnt_clear, in_valid, rs, rt, rd, alu_op, sig_ext,
           read_data1, read_data2, alu_src, reg_dst, mem_to_reg, mem_read,
           reg_write, mem_write, mem_read_width,
    output valid_out, rs_out, rt_out, rd_out, dest_out, alu_op_out, sig_ext_out,
           read_data1_out, read_data2_out, alu_src_out, reg_dst_out,
           mem_to_reg_out, mem_read_out, reg_write_out, mem_write_out,
           mem_read_width_out, load_use_stall, bubble_count
  );

endinterface

// File: rtl/id_ex_stage_ctl_load_use_detect.sv
// Load-use comparator: a valid load in EX whose destination is a source of the valid ID instruction.
// Latency: combinational.
// Backpressure: none; the result is the stall request itself.
module load_use_detect #(
  parameter int RADDR_W = 5
) (
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_reg_write,
  input  logic [RADDR_W-1:0] ex_dest,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  output logic               stall
);
  import id_ex_stage_ctl_pkg::*;

  // Register 0 is hardwired, so a load targeting it never produces a dependency.
  always_comb begin
    stall = ex_valid & ex_mem_read & ex_reg_write & (ex_dest != '0) & id_valid &
            ((ex_dest == id_rs) | (ex_dest == id_rt));
  end

endmodule

// File: rtl/id_ex_stage_ctl.sv
// ID/EX pipeline register with flush, hold, load-use bubble insertion and a saturating bubble counter.
// Latency: one cycle ID inputs to _out outputs; load_use_stall is combinational.
// Backpressure: hold freezes every register; a load-use hazard latches a bubble and raises load_use_stall.
module id_ex_stage_ctl #(
  parameter int DATA_W  = id_ex_stage_ctl_pkg::DATA_W,
  parameter int RADDR_W = id_ex_stage_ctl_pkg::RADDR_W,
  parameter int ALUOP_W = id_ex_stage_ctl_pkg::ALUOP_W,
  parameter int MEMWE_W = id_ex_stage_ctl_pkg::MEMWE_W,
  parameter int MEMRW_W = id_ex_stage_ctl_pkg::MEMRW_W,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  id_ex_stage_ctl_if.slave  bus
);
  import id_ex_stage_ctl_pkg::*;

  logic               valid_q, valid_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic [RADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]  sig_ext_q, sig_ext_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  idex_ctl_t          ctl_q, ctl_d, ctl_in;
  logic [CNT_W-1:0]   bubble_count_q, bubble_count_d;
  logic               stall;
  logic               bubble_take;

  load_use_detect #(.RADDR_W(RADDR_W)) u_load_use_detect (
    .ex_valid     (valid_q),
    .ex_mem_read  (ctl_q.mem_read),
    .ex_reg_write (ctl_q.reg_write),
    .ex_dest      (dest_q),
    .id_valid     (bus.in_valid),
    .id_rs        (bus.rs),
    .id_rt        (bus.rt),
    .stall        (stall)
  );

  // Pack the decoded ID control into the shared bundle.
  always_comb begin
    ctl_in                = IDEX_CTL_NOP;
    ctl_in.alu_op         = bus.alu_op;
    ctl_in.alu_src        = bus.alu_src;
    ctl_in.reg_dst        = bus.reg_dst;
    ctl_in.mem_write      = bus.mem_write;
    ctl_in.mem_to_reg     = bus.mem_to_reg;
    ctl_in.mem_read       = bus.mem_read;
    ctl_in.mem_read_width = bus.mem_read_width;
    ctl_in.reg_write      = bus.reg_write;
  end

  // Next register contents: flush beats hold beats bubble beats a normal load.
  always_comb begin
    valid_d   = valid_q;
    dest_d    = dest_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    sig_ext_d = sig_ext_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    ctl_d     = ctl_q;
    if (bus.flush || (!bus.hold && stall)) begin
      valid_d   = 1'b0;
      dest_d    = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      sig_ext_d = '0;
      rdata1_d  = '0;
      rdata2_d  = '0;
      ctl_d     = IDEX_CTL_NOP;
    end else if (!bus.hold) begin
      valid_d   = bus.in_valid;
      dest_d    = bus.reg_dst ? bus.rd : bus.rt;
      rs_d      = bus.rs;
      rt_d      = bus.rt;
      rd_d      = bus.rd;
      sig_ext_d = bus.sig_ext;
      rdata1_d  = bus.read_data1;
      rdata2_d  = bus.read_data2;
      ctl_d     = bus.in_valid ? ctl_in : ctl_squash_flags(ctl_in);
    end
  end

  // Bubble counter: clear wins over increment, increment saturates at all-ones.
  always_comb begin
    bubble_take    = stall & ~bus.flush & ~bus.hold;
    bubble_count_d = bubble_count_q;
    if (bus.cnt_clear) begin
      bubble_count_d = '0;
    end else if (bubble_take && (bubble_count_q != {CNT_W{1'b1}})) begin
      bubble_count_d = bubble_count_q + 1'b1;
    end
  end

  // Pipeline register and counter state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q        <= 1'b0;
      dest_q         <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      sig_ext_q      <= '0;
      rdata1_q       <= '0;
      rdata2_q       <= '0;
      ctl_q          <= IDEX_CTL_NOP;
      bubble_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      dest_q         <= dest_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      rd_q           <= rd_d;
      sig_ext_q      <= sig_ext_d;
      rdata1_q       <= rdata1_d;
      rdata2_q       <= rdata2_d;
      ctl_q          <= ctl_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.valid_out          = valid_q;
  assign bus.dest_out           = dest_q;
  assign bus.rs_out             = rs_q;
  assign bus.rt_out             = rt_q;
  assign bus.rd_out             = rd_q;
  assign bus.sig_ext_out        = sig_ext_q;
  assign bus.read_data1_out     = rdata1_q;
  assign bus.read_data2_out     = rdata2_q;
  assign bus.alu_op_out         = ctl_q.alu_op;
  assign bus.alu_src_out        = ctl_q.alu_src;
  assign bus.reg_dst_out        = ctl_q.reg_dst;
  assign bus.mem_write_out      = ctl_q.mem_write;
  assign bus.mem_to_reg_out     = ctl_q.mem_to_reg;
  assign bus.mem_read_out       = ctl_q.mem_read;
  assign bus.mem_read_width_out = ctl_q.mem_read_width;
  assign bus.reg_write_out      = ctl_q.reg_write;
  assign bus.load_use_stall     = stall;
  assign bus.bubble_count       = bubble_count_q;

endmodule
